// File: rtl/ysyx_040066_axi_pkg.sv
// Shared constants, FSM state encodings and payload types for the cache-to-AXI bridge.
package ysyx_040066_axi_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned LINE_BEATS = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_ADDR = 3'd1;
  localparam logic [2:0] ST_RD_DATA = 3'd2;
  localparam logic [2:0] ST_WR_ADDR = 3'd3;
  localparam logic [2:0] ST_WR_DATA = 3'd4;
  localparam logic [2:0] ST_WR_RESP = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'd3;
  localparam logic [7:0] LINE_LEN    = 8'(LINE_BEATS - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ID_INS = 2'd0,
    ID_DRD = 2'd1,
    ID_DWR = 2'd2
  } req_id_e;

  // Request captured at grant time.
  typedef struct packed {
    req_id_e           id;
    logic [ADDR_W-1:0] addr;
    logic              burst;
    logic [2:0]        len;
    logic [7:0]        mask;
  } req_t;

  // AXI address-channel payload.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ax_t;

  // Line fills are line-aligned; instruction singles are doubleword-aligned.
  function automatic ax_t ax_from_req(req_t r);
    ax_t a;
    a.burst = BURST_INCR;
    if (r.burst) begin
      a.addr = {r.addr[ADDR_W-1:6], 6'b0};
      a.len  = LINE_LEN;
      a.size = SIZE_8B;
    end else if (r.id == ID_INS) begin
      a.addr = {r.addr[ADDR_W-1:3], 3'b0};
      a.len  = 8'd0;
      a.size = SIZE_8B;
    end else begin
      a.addr = r.addr;
      a.len  = 8'd0;
      a.size = r.len;
    end
    return a;
  endfunction

endpackage

// File: rtl/ysyx_040066_axi_bridge.sv
// Arbitrates icache/dcache memory requests onto a single AXI4 master, one transaction at a time.
module ysyx_040066_axi_bridge
  import ysyx_040066_axi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_req,
  input  logic              ins_burst,
  input  logic [63:0]       ins_addr,
  output logic              ins_ready,
  output logic              ins_err,
  output logic              ins_last,
  output logic [63:0]       ins_data,
  input  logic              rd_req,
  input  logic              rd_burst,
  input  logic [2:0]        rd_len,
  input  logic [63:0]       rd_addr,
  output logic              rd_ready,
  output logic              rd_err,
  output logic              rd_last,
  output logic [63:0]       rd_data,
  input  logic              wr_req,
  input  logic              wr_burst,
  input  logic [2:0]        wr_len,
  input  logic [7:0]        wr_mask,
  input  logic [63:0]       wr_addr,
  input  logic [511:0]      wr_data,
  output logic              wr_ready,
  output logic              wr_err,
  output logic              axi_ar_valid,
  input  logic              axi_ar_ready,
  output logic [ADDR_W-1:0] axi_ar_addr,
  output logic [7:0]        axi_ar_len,
  output logic [2:0]        axi_ar_size,
  output logic [1:0]        axi_ar_burst,
  input  logic              axi_r_valid,
  output logic              axi_r_ready,
  input  logic [63:0]       axi_r_data,
  input  logic [1:0]        axi_r_resp,
  input  logic              axi_r_last,
  output logic              axi_aw_valid,
  input  logic              axi_aw_ready,
  output logic [ADDR_W-1:0] axi_aw_addr,
  output logic [7:0]        axi_aw_len,
  output logic [2:0]        axi_aw_size,
  output logic [1:0]        axi_aw_burst,
  output logic              axi_w_valid,
  input  logic              axi_w_ready,
  output logic [63:0]       axi_w_data,
  output logic [7:0]        axi_w_strb,
  output logic              axi_w_last,
  input  logic              axi_b_valid,
  output logic              axi_b_ready,
  input  logic [1:0]        axi_b_resp
);

  logic [2:0]                       state_q, state_d;
  req_t                             req_q, req_d;
  logic                             grant;
  logic [2:0]                       beat_q, beat_d;
  logic [LINE_BEATS*DATA_W-1:0]     wdata_q;
  ax_t                              ar_q, aw_q;
  logic                             ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic                             unused_bits;

  assign ar_hs = axi_ar_valid & axi_ar_ready;
  assign r_hs  = (state_q == ST_RD_DATA) & axi_r_valid & axi_r_ready;
  assign aw_hs = axi_aw_valid & axi_aw_ready;
  assign w_hs  = axi_w_valid & axi_w_ready;
  assign b_hs  = axi_b_valid & axi_b_ready;

  assign unused_bits = ^{ins_addr[63:ADDR_W], rd_addr[63:ADDR_W], wr_addr[63:ADDR_W],
                         axi_r_resp[0], axi_b_resp[0]};

  assign axi_ar_addr  = ar_q.addr;
  assign axi_ar_len   = ar_q.len;
  assign axi_ar_size  = ar_q.size;
  assign axi_ar_burst = ar_q.burst;
  assign axi_aw_addr  = aw_q.addr;
  assign axi_aw_len   = aw_q.len;
  assign axi_aw_size  = aw_q.size;
  assign axi_aw_burst = aw_q.burst;

  // Next-state, grant and write-beat counter.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    beat_d  = beat_q;
    grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        beat_d = 3'd0;
        if (wr_req) begin
          grant   = 1'b1;
          req_d   = '{id: ID_DWR, addr: wr_addr[ADDR_W-1:0], burst: wr_burst, len: wr_len, mask: wr_mask};
          state_d = ST_WR_ADDR;
        end else if (rd_req) begin
          grant   = 1'b1;
          req_d   = '{id: ID_DRD, addr: rd_addr[ADDR_W-1:0], burst: rd_burst, len: rd_len, mask: 8'h00};
          state_d = ST_RD_ADDR;
        end else if (ins_req) begin
          grant   = 1'b1;
          req_d   = '{id: ID_INS, addr: ins_addr[ADDR_W-1:0], burst: ins_burst, len: SIZE_8B, mask: 8'h00};
          state_d = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: if (ar_hs) state_d = ST_RD_DATA;
      ST_RD_DATA: if (r_hs && axi_r_last) state_d = ST_DONE;
      ST_WR_ADDR: if (aw_hs) state_d = ST_WR_DATA;
      ST_WR_DATA: begin
        if (w_hs) begin
          if (axi_w_last) state_d = ST_WR_RESP;
          else            beat_d  = beat_q + 3'd1;
        end
      end
      ST_WR_RESP: if (b_hs) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Request capture, AXI channel outputs and per-beat requester responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q        <= '0;
      beat_q       <= 3'd0;
      wdata_q      <= '0;
      ar_q         <= '0;
      aw_q         <= '0;
      axi_ar_valid <= 1'b0;
      axi_r_ready  <= 1'b0;
      axi_aw_valid <= 1'b0;
      axi_w_valid  <= 1'b0;
      axi_w_data   <= 64'd0;
      axi_w_strb   <= 8'd0;
      axi_w_last   <= 1'b0;
      axi_b_ready  <= 1'b0;
      ins_ready    <= 1'b0;
      ins_err      <= 1'b0;
      ins_last     <= 1'b0;
      ins_data     <= 64'd0;
      rd_ready     <= 1'b0;
      rd_err       <= 1'b0;
      rd_last      <= 1'b0;
      rd_data      <= 64'd0;
      wr_ready     <= 1'b0;
      wr_err       <= 1'b0;
    end else begin
      req_q  <= req_d;
      beat_q <= beat_d;
      if (grant && (req_d.id == ID_DWR)) begin
        wdata_q <= wr_data;
        aw_q    <= ax_from_req(req_d);
      end
      if (grant && (req_d.id != ID_DWR)) ar_q <= ax_from_req(req_d);

      axi_ar_valid <= (state_d == ST_RD_ADDR);
      axi_r_ready  <= (state_d == ST_RD_DATA);
      axi_aw_valid <= (state_d == ST_WR_ADDR);
      axi_w_valid  <= (state_d == ST_WR_DATA);
      axi_b_ready  <= (state_d == ST_WR_RESP);

      if (state_d == ST_WR_DATA) begin
        axi_w_data <= req_q.burst ? wdata_q[{beat_d, 6'b0} +: DATA_W] : wdata_q[DATA_W-1:0];
        axi_w_strb <= req_q.burst ? 8'hFF : req_q.mask;
        axi_w_last <= req_q.burst ? (beat_d == 3'(LINE_LEN)) : (beat_d == 3'd0);
      end else begin
        axi_w_data <= 64'd0;
        axi_w_strb <= 8'd0;
        axi_w_last <= 1'b0;
      end

      ins_ready <= r_hs & (req_q.id == ID_INS);
      ins_last  <= r_hs & (req_q.id == ID_INS) & axi_r_last;
      ins_err   <= r_hs & (req_q.id == ID_INS) & axi_r_resp[1];
      if (r_hs && (req_q.id == ID_INS)) ins_data <= axi_r_data;

      rd_ready <= r_hs & (req_q.id == ID_DRD);
      rd_last  <= r_hs & (req_q.id == ID_DRD) & axi_r_last;
      rd_err   <= r_hs & (req_q.id == ID_DRD) & axi_r_resp[1];
      if (r_hs && (req_q.id == ID_DRD)) rd_data <= axi_r_data;

      wr_ready <= b_hs;
      wr_err   <= b_hs & axi_b_resp[1];
    end
  end

endmodule

// File: tb/tb_ysyx_040066_axi_bridge.sv
// Randomized bench for the cache-to-AXI bridge with a stalling AXI slave and a transaction-level model.
module tb_ysyx_040066_axi_bridge;
  import ysyx_040066_axi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic ins_req, ins_burst, ins_ready, ins_err, ins_last;
  logic [63:0] ins_addr, ins_data;
  logic rd_req, rd_burst, rd_ready, rd_err, rd_last;
  logic [2:0] rd_len;
  logic [63:0] rd_addr, rd_data;
  logic wr_req, wr_burst, wr_ready, wr_err;
  logic [2:0] wr_len;
  logic [7:0] wr_mask;
  logic [63:0] wr_addr;
  logic [511:0] wr_data;
  logic axi_ar_valid, axi_ar_ready, axi_r_valid, axi_r_ready, axi_r_last;
  logic [31:0] axi_ar_addr, axi_aw_addr;
  logic [7:0] axi_ar_len, axi_aw_len, axi_w_strb;
  logic [2:0] axi_ar_size, axi_aw_size;
  logic [1:0] axi_ar_burst, axi_aw_burst, axi_r_resp, axi_b_resp;
  logic [63:0] axi_r_data, axi_w_data;
  logic axi_aw_valid, axi_aw_ready, axi_w_valid, axi_w_ready, axi_w_last;
  logic axi_b_valid, axi_b_ready;

  ysyx_040066_axi_bridge dut (
    .clk(clk), .rst(rst),
    .ins_req(ins_req), .ins_burst(ins_burst), .ins_addr(ins_addr),
    .ins_ready(ins_ready), .ins_err(ins_err), .ins_last(ins_last), .ins_data(ins_data),
    .rd_req(rd_req), .rd_burst(rd_burst), .rd_len(rd_len), .rd_addr(rd_addr),
    .rd_ready(rd_ready), .rd_err(rd_err), .rd_last(rd_last), .rd_data(rd_data),
    .wr_req(wr_req), .wr_burst(wr_burst), .wr_len(wr_len), .wr_mask(wr_mask),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .wr_err(wr_err),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
    .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size), .axi_ar_burst(axi_ar_burst),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_data(axi_r_data),
    .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_addr(axi_aw_addr),
    .axi_aw_len(axi_aw_len), .axi_aw_size(axi_aw_size), .axi_aw_burst(axi_aw_burst),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
    .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_resp(axi_b_resp)
  );

  typedef struct {logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;} ax_ev_t;
  typedef struct {logic [63:0] data; logic [7:0] strb; logic last;} w_ev_t;
  typedef struct {int port; logic [63:0] data; logic last; logic err;} rsp_ev_t;

  ax_ev_t  obs_ar_q[$], obs_aw_q[$], exp_ar_q[$], exp_aw_q[$];
  w_ev_t   obs_w_q[$], exp_w_q[$];
  rsp_ev_t obs_rsp_q[$], exp_rsp_q[$];

  int n_run = 0, n_fail = 0;

  // Slave configuration and bookkeeping.
  int p_go = 100;
  bit wtoggle = 1'b0;
  logic [63:0] rbase = 64'd0;
  int err_beat = 99;
  logic [1:0] bresp_cfg = RESP_OKAY;
  int cyc = 0;
  int ins_seen = 0, rd_seen = 0, wr_seen = 0, rd_beats = 0;
  bit rd_active, b_pend, ar_p, r_p, r_last_p, w_p, w_last_p, b_p;
  int rbeat, rlen;
  logic [7:0] rlen_n;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic any_out();
    return |{ins_ready, ins_err, ins_last, ins_data, rd_ready, rd_err, rd_last, rd_data,
             wr_ready, wr_err, axi_ar_valid, axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst,
             axi_r_ready, axi_aw_valid, axi_aw_addr, axi_aw_len, axi_aw_size, axi_aw_burst,
             axi_w_valid, axi_w_data, axi_w_strb, axi_w_last, axi_b_ready};
  endfunction

  task automatic slave_reset();
    axi_ar_ready = 0; axi_r_valid = 0; axi_r_data = 0; axi_r_resp = 0; axi_r_last = 0;
    axi_aw_ready = 0; axi_w_ready = 0; axi_b_valid = 0; axi_b_resp = 0;
    rd_active = 0; b_pend = 0; ar_p = 0; r_p = 0; r_last_p = 0; w_p = 0; w_last_p = 0; b_p = 0;
    rbeat = 0; rlen = 0; rlen_n = 0;
  endtask

  // AXI slave plus requester-side monitor; handshakes are predicted at the negedge before the edge that takes them.
  initial begin
    slave_reset();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        slave_reset();
      end else begin
        if (ins_ready) begin obs_rsp_q.push_back('{0, ins_data, ins_last, ins_err}); if (ins_last) ins_seen++; end
        if (rd_ready) begin obs_rsp_q.push_back('{1, rd_data, rd_last, rd_err}); rd_beats++; if (rd_last) rd_seen++; end
        if (wr_ready) begin obs_rsp_q.push_back('{2, 64'd0, 1'b0, wr_err}); wr_seen++; end
        if (ar_p) begin rd_active = 1; rbeat = 0; rlen = int'(rlen_n); end
        if (r_p) begin axi_r_valid = 0; rbeat++; if (r_last_p) rd_active = 0; end
        if (w_p && w_last_p) b_pend = 1;
        if (b_p) begin axi_b_valid = 0; b_pend = 0; end
        axi_ar_ready = axi_ar_valid && ($urandom_range(99) < p_go);
        axi_aw_ready = axi_aw_valid && ($urandom_range(99) < p_go);
        axi_w_ready  = wtoggle ? cyc[0] : ($urandom_range(99) < p_go);
        if (rd_active && !axi_r_valid && ($urandom_range(99) < p_go)) begin
          axi_r_valid = 1;
          axi_r_data  = rbase + 64'(rbeat);
          axi_r_resp  = (rbeat == err_beat) ? RESP_DECERR : RESP_OKAY;
          axi_r_last  = (rbeat == rlen);
        end
        if (b_pend && !axi_b_valid && ($urandom_range(99) < p_go)) begin
          axi_b_valid = 1; axi_b_resp = bresp_cfg;
        end
        ar_p = axi_ar_valid && axi_ar_ready;
        if (ar_p) begin
          obs_ar_q.push_back('{axi_ar_addr, axi_ar_len, axi_ar_size, axi_ar_burst});
          rlen_n = axi_ar_len;
        end
        if (axi_aw_valid && axi_aw_ready)
          obs_aw_q.push_back('{axi_aw_addr, axi_aw_len, axi_aw_size, axi_aw_burst});
        r_p = axi_r_valid && axi_r_ready; r_last_p = axi_r_last;
        w_p = axi_w_valid && axi_w_ready; w_last_p = axi_w_last;
        if (w_p) obs_w_q.push_back('{axi_w_data, axi_w_strb, axi_w_last});
        b_p = axi_b_valid && axi_b_ready;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  // Reference model: what one request must produce on AXI and back at the requester.
  function automatic void expect_txn(int port, bit burst, logic [63:0] addr, logic [2:0] len,
                                     logic [7:0] mask, logic [511:0] wd, int errb, logic [1:0] br);
    int n = burst ? 8 : 1;
    ax_ev_t a;
    logic [31:0] a32 = addr[31:0];
    if (burst)          a.addr = a32 & 32'hFFFF_FFC0;
    else if (port == 0) a.addr = a32 & 32'hFFFF_FFF8;
    else                a.addr = a32;
    a.len   = 8'(n - 1);
    a.size  = (burst || port == 0) ? 3'd3 : len;
    a.burst = 2'b01;
    if (port == 2) begin
      exp_aw_q.push_back(a);
      for (int i = 0; i < n; i++)
        exp_w_q.push_back('{wd[64*i +: 64], burst ? 8'hFF : mask, (i == n - 1)});
      exp_rsp_q.push_back('{2, 64'd0, 1'b0, br[1]});
    end else begin
      exp_ar_q.push_back(a);
      for (int i = 0; i < n; i++)
        exp_rsp_q.push_back('{port, rbase + 64'(i), (i == n - 1), (i == errb)});
    end
  endfunction

  task automatic issue(int port, bit burst, logic [63:0] addr, logic [2:0] len,
                       logic [7:0] mask, logic [511:0] wd);
    case (port)
      0: begin ins_req = 1; ins_burst = burst; ins_addr = addr; end
      1: begin rd_req = 1; rd_burst = burst; rd_addr = addr; rd_len = len; end
      default: begin wr_req = 1; wr_burst = burst; wr_addr = addr; wr_len = len; wr_mask = mask; wr_data = wd; end
    endcase
  endtask

  task automatic wait_done(string tag, bit need_ins, bit need_rd, bit need_wr);
    bit done = 0;
    ins_seen = 0; rd_seen = 0; wr_seen = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      tick();
      if (ins_seen > 0) ins_req = 0;
      if (rd_seen > 0)  rd_req = 0;
      if (wr_seen > 0)  wr_req = 0;
      done = (!need_ins || ins_seen > 0) && (!need_rd || rd_seen > 0) && (!need_wr || wr_seen > 0);
    end
    chk({tag, "_complete"}, 64'(done), 64'd1);
    ins_req = 0; rd_req = 0; wr_req = 0;
    repeat (5) tick();
  endtask

  task automatic clear_queues();
    obs_ar_q.delete(); obs_aw_q.delete(); obs_w_q.delete(); obs_rsp_q.delete();
    exp_ar_q.delete(); exp_aw_q.delete(); exp_w_q.delete(); exp_rsp_q.delete();
  endtask

  task automatic compare_all(string tag);
    chk({tag, "_ar_cnt"}, 64'(obs_ar_q.size()), 64'(exp_ar_q.size()));
    for (int i = 0; i < obs_ar_q.size() && i < exp_ar_q.size(); i++)
      chk($sformatf("%s_ar[%0d]", tag, i),
          {19'd0, obs_ar_q[i].addr, obs_ar_q[i].len, obs_ar_q[i].size, obs_ar_q[i].burst},
          {19'd0, exp_ar_q[i].addr, exp_ar_q[i].len, exp_ar_q[i].size, exp_ar_q[i].burst});
    chk({tag, "_aw_cnt"}, 64'(obs_aw_q.size()), 64'(exp_aw_q.size()));
    for (int i = 0; i < obs_aw_q.size() && i < exp_aw_q.size(); i++)
      chk($sformatf("%s_aw[%0d]", tag, i),
          {19'd0, obs_aw_q[i].addr, obs_aw_q[i].len, obs_aw_q[i].size, obs_aw_q[i].burst},
          {19'd0, exp_aw_q[i].addr, exp_aw_q[i].len, exp_aw_q[i].size, exp_aw_q[i].burst});
    chk({tag, "_w_cnt"}, 64'(obs_w_q.size()), 64'(exp_w_q.size()));
    for (int i = 0; i < obs_w_q.size() && i < exp_w_q.size(); i++) begin
      chk($sformatf("%s_w_data[%0d]", tag, i), obs_w_q[i].data, exp_w_q[i].data);
      chk($sformatf("%s_w_strb_last[%0d]", tag, i), {55'd0, obs_w_q[i].strb, obs_w_q[i].last},
          {55'd0, exp_w_q[i].strb, exp_w_q[i].last});
    end
    chk({tag, "_rsp_cnt"}, 64'(obs_rsp_q.size()), 64'(exp_rsp_q.size()));
    for (int i = 0; i < obs_rsp_q.size() && i < exp_rsp_q.size(); i++) begin
      chk($sformatf("%s_rsp_port_last_err[%0d]", tag, i),
          {32'(obs_rsp_q[i].port), 30'd0, obs_rsp_q[i].last, obs_rsp_q[i].err},
          {32'(exp_rsp_q[i].port), 30'd0, exp_rsp_q[i].last, exp_rsp_q[i].err});
      chk($sformatf("%s_rsp_data[%0d]", tag, i), obs_rsp_q[i].data, exp_rsp_q[i].data);
    end
    clear_queues();
  endtask

  task automatic run_txn(string tag, int port, bit burst, logic [63:0] addr, logic [2:0] len,
                         logic [7:0] mask, logic [511:0] wd, int errb, logic [1:0] br);
    err_beat = errb; bresp_cfg = br;
    expect_txn(port, burst, addr, len, mask, wd, errb, br);
    issue(port, burst, addr, len, mask, wd);
    wait_done(tag, port == 0, port == 1, port == 2);
    compare_all(tag);
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    bit ok;
    rst = 1;
    ins_req = 0; ins_burst = 0; ins_addr = 0;
    rd_req = 0; rd_burst = 0; rd_len = 0; rd_addr = 0;
    wr_req = 0; wr_burst = 0; wr_len = 0; wr_mask = 0; wr_addr = 0; wr_data = 0;
    repeat (3) tick();
    chk("reset_outputs", 64'(any_out()), 64'd0);
    rst = 0;
    tick();

    rbase = 64'd0; p_go = 100;
    run_txn("ins_line", 0, 1'b1, 64'h8000_0044, 3'd0, 8'h00, '0, 99, RESP_OKAY);

    rbase = 64'h1000; p_go = 80; err_beat = 99;
    expect_txn(1, 1'b1, 64'h9000_0120, 3'd0, 8'h00, '0, 99, RESP_OKAY);
    expect_txn(0, 1'b0, 64'h8000_0014, 3'd0, 8'h00, '0, 99, RESP_OKAY);
    issue(1, 1'b1, 64'h9000_0120, 3'd0, 8'h00, '0);
    issue(0, 1'b0, 64'h8000_0014, 3'd0, 8'h00, '0);
    wait_done("arb", 1'b1, 1'b1, 1'b0);
    compare_all("arb");

    p_go = 100;
    run_txn("wr_single", 2, 1'b0, 64'hA000_0003, 3'd0, 8'h08, rand_line(), 99, RESP_SLVERR);

    wtoggle = 1;
    run_txn("wr_line_toggle", 2, 1'b1, 64'h0000_0000_A000_0108, 3'd0, 8'h00, rand_line(), 99, RESP_OKAY);
    wtoggle = 0;

    rbase = {$urandom, $urandom}; p_go = 60;
    run_txn("rd_decerr", 1, 1'b1, 64'h8000_2000, 3'd0, 8'h00, '0, 2, RESP_OKAY);

    p_go = 100; rbase = 64'h55; err_beat = 99; rd_beats = 0;
    issue(1, 1'b1, 64'h8000_3000, 3'd0, 8'h00, '0);
    ok = 0;
    for (int c = 0; c < 500 && !ok; c++) begin
      tick();
      ok = (rd_beats >= 4);
    end
    chk("rst_mid_reached_beat4", 64'(ok), 64'd1);
    rst = 1;
    #1;
    chk("rst_mid_outputs", 64'(any_out()), 64'd0);
    rd_req = 0;
    repeat (2) tick();
    rst = 0;
    tick();
    clear_queues();
    rbase = 64'h77;
    run_txn("after_rst", 1, 1'b0, 64'h8000_3004, 3'd2, 8'h00, '0, 99, RESP_OKAY);

    for (int t = 0; t < 40; t++) begin
      int port = $urandom_range(2);
      rbase = {$urandom, $urandom};
      p_go = $urandom_range(30, 100);
      run_txn($sformatf("rand%0d", t), port, 1'($urandom_range(1)), {$urandom, $urandom},
              3'($urandom_range(3)), 8'($urandom), rand_line(), $urandom_range(9),
              2'($urandom_range(3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
